// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, with sign fix-up in a final cycle.
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIXUP, DONE} state_t;

    state_t             state;
    state_t             next_state;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH:0]     rem;
    logic               neg_result;
    logic               neg_rem;
    logic               is_div;
    logic               zero_div;

    logic               start_mul;
    logic               start_div;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               last_step;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_trial;
    logic               div_ge;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign start_mul = start && (op[2:1] == 2'b00);
    assign start_div = start && (op[2:1] == 2'b01);
    assign a_neg     = !op[0] && rs_data[WIDTH-1];
    assign b_neg     = !op[0] && rt_data[WIDTH-1];
    assign a_mag     = a_neg ? -rs_data : rs_data;
    assign b_mag     = b_neg ? -rt_data : rt_data;
    assign last_step = (count == CW'(WIDTH - 1));

    // Multiply: acc = {partial product, remaining multiplier bits}.
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
    // Divide: dividend bits shift out of acc's low half while quotient bits shift in.
    assign div_trial = {rem, acc[WIDTH-1]};
    assign div_ge    = (div_trial >= {2'b00, opb});
    assign div_diff  = div_trial[WIDTH:0] - {1'b0, opb};

    assign prod_fix  = neg_result ? -acc : acc;
    assign quot_fix  = zero_div ? {WIDTH{1'b1}} : (neg_result ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    assign rem_fix   = neg_rem ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_mul)      next_state = MUL;
                else if (start_div) next_state = DIV;
            end
            MUL, DIV: begin
                if (abort)          next_state = IDLE;
                else if (last_step) next_state = FIXUP;
            end
            FIXUP:   next_state = abort ? IDLE : DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state == MUL) || (state == DIV) || (state == FIXUP);
        done        = (state == DONE);
        div_by_zero = (state == DONE) && zero_div;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            acc        <= '0;
            opb        <= '0;
            rem        <= '0;
            neg_result <= 1'b0;
            neg_rem    <= 1'b0;
            is_div     <= 1'b0;
            zero_div   <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_mul || start_div) begin
                        count      <= '0;
                        acc        <= {{WIDTH{1'b0}}, (start_mul ? b_mag : a_mag)};
                        opb        <= start_mul ? a_mag : b_mag;
                        rem        <= '0;
                        neg_result <= a_neg ^ b_neg;
                        neg_rem    <= a_neg;
                        is_div     <= start_div;
                        zero_div   <= start_div && (rt_data == '0);
                    end else if (start && op == 3'b100) begin
                        hi <= rs_data;
                    end else if (start && op == 3'b101) begin
                        lo <= rs_data;
                    end
                end
                MUL: begin
                    acc   <= {mul_sum, acc[WIDTH-1:1]};
                    count <= count + 1'b1;
                end
                DIV: begin
                    rem            <= div_ge ? div_diff : div_trial[WIDTH:0];
                    acc[WIDTH-1:0] <= {acc[WIDTH-2:0], div_ge};
                    count          <= count + 1'b1;
                end
                FIXUP: begin
                    if (!abort) begin
                        if (is_div) begin
                            lo <= quot_fix;
                            hi <= rem_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
Iterative multiply/divide unit with HI/LO registers for the MIPS processor. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO, and is parametrised in datapath width. It sits beside the ALU in the execute stage. The control unit starts an operation, stalls on busy, and reads hi/lo for MFHI/MFLO.

Parameters:
WIDTH, 32, operand and HI/LO width (even, >= 4)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  operation request; sampled only in IDLE
op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved
rs_data  in  WIDTH  operand A (dividend / multiplicand / MTHI/MTLO source)
rt_data  in  WIDTH  operand B (divisor / multiplier)
abort  in  1  cancel an in-flight MUL/DIV
busy  out  1  high while an operation is in flight
done  out  1  one-cycle pulse when hi/lo take a MUL/DIV result
div_by_zero  out  1  one-cycle pulse coincident with done for a zero divisor
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0):
  - hi=0, lo=0, busy=0, done=0, div_by_zero=0.
  - FSM goes to IDLE and all internal datapath registers are cleared.
  - Takes effect immediately, including mid-operation.
- FSM states: IDLE, MUL, DIV, FIXUP, DONE.
- IDLE:
  - start=1 with op MULT/MULTU goes to MUL; with op DIV/DIVU goes to DIV.
  - Operands are latched on that edge (edge T).
  - If op is signed, operand magnitudes are latched and result sign and remainder sign are recorded.
  - MTHI: hi<=rs_data at edge T; MTLO: lo<=rs_data at edge T. FSM stays in IDLE, no busy, no done.
  - Reserved op codes: no state change.
- MUL:
  - Shift-add, one multiplier bit per cycle, WIDTH cycles.
  - 2*WIDTH-bit product accumulator.
- DIV:
  - Restoring division, one quotient bit per cycle, WIDTH cycles.
  - WIDTH+1-bit partial remainder.
- FIXUP (1 cycle):
  - Two's-complement negation of the product, or of quotient/remainder, as recorded.
  - Quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - The 2*WIDTH product is split as HI = upper half, LO = lower half.
  - Division: LO = quotient, HI = remainder.
  - hi/lo are written on the edge leaving FIXUP.
- DONE (1 cycle): done=1, busy=0; next state IDLE. start is not accepted in DONE.
- Latency:
  - busy=1 from T+1 through T+WIDTH+1.
  - done=1 and new hi/lo are visible in cycle T+WIDTH+2.
  - Next start is accepted at edge T+WIDTH+3.
  - For WIDTH=32, the result appears 34 cycles after start.
- Divide by zero (rt_data=0):
  - Takes the same latency.
  - Result is LO = all ones, HI = dividend (original signed value for DIV).
  - div_by_zero pulses with done.
- Signed overflow: DIV of -2^(WIDTH-1) by -1 gives LO = -2^(WIDTH-1), HI = 0 (wraps; no flag).
- start while busy or in DONE: ignored; in-flight operation unaffected.
- abort=1 while busy:
  - FSM returns to IDLE on the next edge; busy=0 the cycle after.
  - hi/lo keep their pre-operation values; no done.
  - abort in IDLE has no effect.
  - If abort and start coincide in IDLE, start is accepted.
- hi/lo change only on MTHI, MTLO, completion of MUL/DIV, or reset.

Test Plan:
1. WIDTH=32, MULT rs=0xFFFFFFFD (-3), rt=7, start at T -> busy T+1..T+33; done=1 at T+34; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
2. MULTU rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Then MULT with same operands -> HI=0x00000000, LO=0x00000001.
3. DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU rs=7, rt=2 -> LO=3, HI=1. DIV rs=0x80000000, rt=0xFFFFFFFF -> LO=0x80000000, HI=0.
4. DIV rs=5, rt=0 -> at T+34 done=1, div_by_zero=1, LO=0xFFFFFFFF, HI=5. Next DIVU 9/3 -> div_by_zero=0, LO=3, HI=0.
5. Preload MTHI 0x11, MTLO 0x22 (both visible next cycle, no busy). Start MULTU 3*4, pulse start again with different operands at T+5 (ignored), then abort at T+10 -> busy=0 by T+12, no done, HI=0x11, LO=0x22.
6. Start DIVU 100/7, deassert rst_n at T+15 -> hi=lo=0, busy=done=0 immediately. After release, DIVU 100/7 -> LO=14, HI=2 at 34 cycles.
